// File: rtl/cpu_pkg.sv
// Shared MIPS datapath constants and the fetch sequencer state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 128;
    localparam logic [31:0] HALT_WORD  = 32'h0000_000C;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the program counter, addresses instruction memory and registers each
// fetched word for decode; handles stall, redirect, halt and address faults.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int          IMEM_WORDS = cpu_pkg::IMEM_WORDS,
    parameter logic [31:0] HALT_WORD  = cpu_pkg::HALT_WORD,
    parameter int          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [31:0]      RedirectPC,
    output logic [31:0]      ImemAddress,
    input  logic [31:0]      ImemInstruction,
    output logic [31:0]      IfInstruction,
    output logic [31:0]      IfPC,
    output logic             IfValid,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] FetchCount
);
    import cpu_pkg::*;

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    fetch_state_e state;
    logic [31:0]  pc;

    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < IMEM_BYTES);
    endfunction

    assign ImemAddress = pc;

    // A redirect may arrive while draining: an older branch resolving ahead of the halt.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            IfInstruction <= '0;
            IfPC          <= '0;
            IfValid       <= 1'b0;
            Halted        <= 1'b0;
            Fault         <= 1'b0;
            FetchCount    <= '0;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (Redirect) begin
                        pc      <= RedirectPC;
                        IfValid <= 1'b0;
                        if (!addr_ok(RedirectPC)) begin
                            state <= FAULT;
                            Fault <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else if (state == DRAIN) begin
                        if (IfValid && !Stall) begin
                            IfValid <= 1'b0;
                            Halted  <= 1'b1;
                            state   <= HALT;
                        end
                    end else if (!(IfValid && Stall)) begin
                        if (pc >= IMEM_BYTES) begin
                            state   <= FAULT;
                            Fault   <= 1'b1;
                            IfValid <= 1'b0;
                        end else begin
                            IfInstruction <= ImemInstruction;
                            IfPC          <= pc;
                            IfValid       <= 1'b1;
                            if (FetchCount != '1)
                                FetchCount <= FetchCount + CNT_W'(1);
                            // The halt word is delivered but the PC stays on it.
                            if (ImemInstruction == HALT_WORD)
                                state <= DRAIN;
                            else
                                pc <= pc + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory model.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IfInstruction;
    logic [31:0] IfPC;
    logic        IfValid;
    logic        Halted;
    logic        Fault;
    logic [15:0] FetchCount;

    logic [31:0] mem [0:127];
    int errors = 0;
    int checks = 0;

    fetch_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .ImemAddress(ImemAddress),
        .ImemInstruction(ImemInstruction), .IfInstruction(IfInstruction),
        .IfPC(IfPC), .IfValid(IfValid), .Halted(Halted), .Fault(Fault),
        .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        ImemInstruction = '0;
        if (ImemAddress < 32'd512)
            ImemInstruction = mem[ImemAddress[8:2]];
    end

    // Word 4 would read 12, which is the syscall encoding, so it is replaced.
    task automatic load_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3);
        mem[4] = 32'h0000_0024;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        #2;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        load_mem();
        Rst = 1'b0;
        #2;
        checks++; if (IfValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ifvalid got %b want 0", IfValid); end
        checks++; if (IfInstruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_ifinstr got %h want 0", IfInstruction); end
        checks++; if (IfPC !== 32'h0) begin errors++; $display("[TB] FAIL reset_ifpc got %h want 0", IfPC); end
        checks++; if (Halted !== 1'b0 || Fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b want 00", Halted, Fault); end
        checks++; if (FetchCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", FetchCount); end
        checks++; if (ImemAddress !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", ImemAddress); end
    endtask

    task automatic test_free_run();
        load_mem();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (IfValid !== 1'b1 || IfPC !== 32'(k * 4) || IfInstruction !== 32'(k * 3)) begin
                errors++;
                $display("[TB] FAIL run_fetch%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         k, IfValid, IfPC, IfInstruction, 32'(k * 4), 32'(k * 3));
            end
        end
        checks++; if (FetchCount !== 16'd4) begin errors++; $display("[TB] FAIL run_count got %0d want 4", FetchCount); end
        checks++; if (ImemAddress !== 32'h10) begin errors++; $display("[TB] FAIL run_addr got %h want 10", ImemAddress); end
    endtask

    task automatic test_stall();
        load_mem();
        do_reset();
        repeat (3) step();
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (IfValid !== 1'b1 || IfPC !== 32'h8 || IfInstruction !== 32'd6 ||
                ImemAddress !== 32'hC || FetchCount !== 16'd3) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got v=%b pc=%h ins=%h addr=%h cnt=%0d want 1 8 6 c 3",
                         k, IfValid, IfPC, IfInstruction, ImemAddress, FetchCount);
            end
        end
        Stall = 1'b0;
        step();
        checks++;
        if (IfPC !== 32'hC || IfInstruction !== 32'd9 || FetchCount !== 16'd4) begin
            errors++;
            $display("[TB] FAIL stall_release got pc=%h ins=%h cnt=%0d want c 9 4", IfPC, IfInstruction, FetchCount);
        end
    endtask

    task automatic test_redirect();
        load_mem();
        do_reset();
        repeat (2) step();
        Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h40;
        step();
        Redirect = 1'b0;
        checks++;
        if (IfValid !== 1'b0 || ImemAddress !== 32'h40 || Fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_flush got v=%b addr=%h f=%b want 0 40 0", IfValid, ImemAddress, Fault);
        end
        step();
        Stall = 1'b0;
        checks++;
        if (IfValid !== 1'b1 || IfPC !== 32'h40 || IfInstruction !== 32'd48 || FetchCount !== 16'd3) begin
            errors++;
            $display("[TB] FAIL redir_target got v=%b pc=%h ins=%0d cnt=%0d want 1 40 48 3",
                     IfValid, IfPC, IfInstruction, FetchCount);
        end
    endtask

    task automatic test_halt();
        load_mem();
        mem[5] = 32'h0000_000C;
        do_reset();
        repeat (6) step();
        checks++;
        if (IfValid !== 1'b1 || IfPC !== 32'h14 || IfInstruction !== 32'hC || Halted !== 1'b0 || ImemAddress !== 32'h14) begin
            errors++;
            $display("[TB] FAIL halt_deliver got v=%b pc=%h ins=%h h=%b addr=%h want 1 14 c 0 14",
                     IfValid, IfPC, IfInstruction, Halted, ImemAddress);
        end
        step();
        checks++;
        if (IfValid !== 1'b0 || Halted !== 1'b1 || ImemAddress !== 32'h14 || FetchCount !== 16'd6) begin
            errors++;
            $display("[TB] FAIL halt_enter got v=%b h=%b addr=%h cnt=%0d want 0 1 14 6", IfValid, Halted, ImemAddress, FetchCount);
        end
        Redirect = 1'b1; RedirectPC = 32'h0;
        repeat (2) step();
        Redirect = 1'b0;
        checks++;
        if (IfValid !== 1'b0 || Halted !== 1'b1 || ImemAddress !== 32'h14) begin
            errors++;
            $display("[TB] FAIL halt_ignore got v=%b h=%b addr=%h want 0 1 14", IfValid, Halted, ImemAddress);
        end
    endtask

    task automatic test_fault_redirect();
        load_mem();
        do_reset();
        step();
        Redirect = 1'b1; RedirectPC = 32'h202;
        step();
        checks++;
        if (Fault !== 1'b1 || IfValid !== 1'b0) begin
            errors++; $display("[TB] FAIL fault_misalign got f=%b v=%b want 1 0", Fault, IfValid);
        end
        RedirectPC = 32'h10;
        repeat (2) step();
        Redirect = 1'b0;
        checks++;
        if (Fault !== 1'b1 || IfValid !== 1'b0 || ImemAddress !== 32'h202) begin
            errors++; $display("[TB] FAIL fault_sticky got f=%b v=%b addr=%h want 1 0 202", Fault, IfValid, ImemAddress);
        end
        do_reset();
        step();
        Redirect = 1'b1; RedirectPC = 32'h200;
        step();
        Redirect = 1'b0;
        checks++;
        if (Fault !== 1'b1 || IfValid !== 1'b0) begin
            errors++; $display("[TB] FAIL fault_range got f=%b v=%b want 1 0", Fault, IfValid);
        end
        do_reset();
        Redirect = 1'b1; RedirectPC = 32'h1FC;
        step();
        Redirect = 1'b0;
        step();
        checks++;
        if (Fault !== 1'b0 || IfValid !== 1'b1 || IfPC !== 32'h1FC || IfInstruction !== 32'd381) begin
            errors++;
            $display("[TB] FAIL redir_lastword got f=%b v=%b pc=%h ins=%0d want 0 1 1fc 381", Fault, IfValid, IfPC, IfInstruction);
        end
    endtask

    task automatic test_sequential_end();
        load_mem();
        do_reset();
        repeat (128) step();
        checks++;
        if (IfValid !== 1'b1 || IfPC !== 32'h1FC || IfInstruction !== 32'd381 || FetchCount !== 16'd128 || Fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_last got v=%b pc=%h ins=%0d cnt=%0d f=%b want 1 1fc 381 128 0",
                     IfValid, IfPC, IfInstruction, FetchCount, Fault);
        end
        step();
        checks++;
        if (Fault !== 1'b1 || IfValid !== 1'b0 || ImemAddress !== 32'h200 || FetchCount !== 16'd128) begin
            errors++;
            $display("[TB] FAIL seq_fault got f=%b v=%b addr=%h cnt=%0d want 1 0 200 128", Fault, IfValid, ImemAddress, FetchCount);
        end
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        checks++;
        if (Fault !== 1'b0 || IfValid !== 1'b0 || IfPC !== 32'h0 || IfInstruction !== 32'h0 ||
            FetchCount !== 16'd0 || ImemAddress !== 32'h0 || Halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got f=%b v=%b pc=%h ins=%h cnt=%0d addr=%h h=%b want all zero",
                     Fault, IfValid, IfPC, IfInstruction, FetchCount, ImemAddress, Halted);
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_halt();
        test_fault_redirect();
        test_sequential_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
